fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side consumer for the team's synchronous FIFO. It drives the FIFO read port (read enable, empty flag, registered read data, read-done strobe) and converts it into a valid/ready stream toward downstream logic. A 2-entry output buffer hides the FIFO's one-cycle read latency, so full throughput is sustained under back-pressure and no word is ever lost or duplicated. It sits between a FIFO instance and any stream sink in the same clock domain.

## Interface
Parameters:
- G_WIDTH, 8, data word width; must match the FIFO G_WIDTH.
- G_CNT_WIDTH, 32, width of the delivered-word counter (used only with FIFO_RD_STATS_EN).

Ports:
- i_clk  in  1  single clock for the block, rising edge; drives the FIFO read clock.
- i_rst_n  in  1  asynchronous active-low reset.
- o_fifo_rd  out  1  FIFO read enable (combinational).
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_data  in  G_WIDTH  FIFO read data; valid when i_fifo_rd_done=1.
- i_fifo_rd_done  in  1  FIFO read-completed strobe; one cycle after an accepted read.
- i_flush  in  1  synchronous flush: drop buffered and in-flight words.
- o_valid  out  1  stream word valid.
- i_ready  in  1  downstream ready.
- o_data  out  G_WIDTH  stream data (buffer head).
- o_rd_count  out  G_CNT_WIDTH  delivered-word count.

## Operation
- State: 2-entry buffer (regs buf0/buf1, count cnt 0..2), inflight flag (registered o_fifo_rd), discard flag.
- pop = o_valid & i_ready. o_valid = (cnt != 0). o_data = buf0.
- o_fifo_rd = i_rst_n & !i_fifo_empty & !i_flush & ((cnt + inflight - pop) < 2). Arithmetic is 3-bit unsigned and never negative, because pop implies cnt ≥ 1.
- Capture: when i_fifo_rd_done & !discard, write i_fifo_data into the first free slot after any pop. Simultaneous pop and capture at cnt=1 leaves cnt=1 with buf0 = new word.
- Pop shifts buf1 to buf0. cnt_next = cnt + capture - pop. The credit rule guarantees cnt never exceeds 2.
- Flush (i_flush=1 at an edge): cnt←0. discard←inflight, so the word already requested is dropped on arrival. A pop in the flush cycle still completes. o_fifo_rd=0 during flush.
- discard clears on the cycle the dropped word's i_fifo_rd_done arrives.
- i_fifo_rd_done without a preceding o_fifo_rd is a protocol error: ignored when cnt=2, captured otherwise. Do not rely on this.
- Reset values (async, i_rst_n=0): cnt=0, inflight=0, discard=0, buf0/buf1=0, o_valid=0, o_data=0, o_fifo_rd=0, o_rd_count=0.

## Timing
- Latency: FIFO non-empty and buffer empty in cycle N → o_fifo_rd=1 in N → i_fifo_rd_done in N+1 → o_valid=1 in N+2.
- Throughput: one word per cycle when the FIFO stays non-empty and i_ready=1 continuously.
- Back-pressure: o_valid/o_data hold stable while o_valid & !i_ready. At most 2 words are buffered plus 0 in flight, or 1 buffered plus 1 in flight.
- o_fifo_rd depends combinationally on i_ready, i_fifo_empty and i_flush. There is no other combinational input-to-output path.
- Reset mid-transfer: all state clears immediately. A FIFO read strobe arriving after reset release with inflight=0 is captured per the rule above. System-level reset of the FIFO and this block together is required.

## Configuration
- FIFO_RD_STATS_EN defined: o_rd_count increments by 1 on every pop and wraps modulo 2^G_CNT_WIDTH. It is not cleared by i_flush, only by reset.
- FIFO_RD_STATS_EN undefined: the counter is not built and o_rd_count is tied to 0. The port remains present.

## Test plan
- FIFO preloaded with 0x11,0x22,0x33, i_ready=1 → o_fifo_rd at cycles 0,1,2. Stream delivers 0x11,0x22,0x33 on cycles 2,3,4, then o_valid=0.
- FIFO holding 8 words, i_ready=0 → exactly 2 reads issued. o_valid=1, o_data=first word stable. After i_ready=1, all 8 words delivered in order on 8 consecutive cycles.
- Empty FIFO, i_ready=1 → o_fifo_rd stays 0 and o_valid stays 0. No FIFO underflow is raised.
- Buffer holding 0xA1,0xA2 with one read in flight (0xA3), then i_flush pulse → o_valid=0 the next cycle and 0xA3 is discarded. The next FIFO word, 0xA4, is the first delivered.
- Reset asserted while cnt=2 → o_valid=0, o_data=0, o_rd_count=0 immediately, without waiting for a clock edge.
- With FIFO_RD_STATS_EN and G_CNT_WIDTH=4, deliver 17 words → o_rd_count=1. Without the macro → o_rd_count=0 throughout.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side consumer for the synchronous FIFO. Issues FIFO reads on credit and
//   presents the words as a valid/ready stream. A 2-entry buffer absorbs the FIFO's
//   one-cycle read latency so a word per cycle is sustained under back-pressure.
//
//   Optional feature: define FIFO_RD_STATS_EN to build the delivered-word counter;
//   otherwise o_rd_count is tied to 0.
//
// Ports
//   i_clk           clock, rising edge (also the FIFO read clock)
//   i_rst_n         asynchronous active-low reset
//   o_fifo_rd       FIFO read enable (combinational)
//   i_fifo_empty    FIFO empty flag
//   i_fifo_data     FIFO read data, valid with i_fifo_rd_done
//   i_fifo_rd_done  FIFO read-completed strobe, one cycle after an accepted read
//   i_flush         synchronous flush of buffered and in-flight words
//   o_valid         stream word valid
//   i_ready         downstream ready
//   o_data          stream data (buffer head)
//   o_rd_count      delivered-word count (wraps)
module fifo_stream_reader #(
  parameter int unsigned G_WIDTH     = 8,
  parameter int unsigned G_CNT_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic                   o_fifo_rd,
  input  logic                   i_fifo_empty,
  input  logic [G_WIDTH-1:0]     i_fifo_data,
  input  logic                   i_fifo_rd_done,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [G_WIDTH-1:0]     o_data,
  output logic [G_CNT_WIDTH-1:0] o_rd_count
);

  logic [1:0]         cnt_q, cnt_d, cnt_after_pop;
  logic               inflight_q;
  logic               discard_q, discard_d;
  logic [G_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic               pop, capture;
  logic [2:0]         credit;

  assign o_valid = (cnt_q != 2'd0);
  assign o_data  = buf0_q;
  assign pop     = o_valid & i_ready;

  // Words held or owed after this cycle's pop; pop implies cnt_q >= 1 so no underflow.
  assign credit    = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign o_fifo_rd = i_rst_n & ~i_fifo_empty & ~i_flush & (credit < 3'd2);

  // A word arriving during a flush is the in-flight one being dropped.
  assign capture = i_fifo_rd_done & ~discard_q & ~i_flush & (cnt_q != 2'd2);

  assign cnt_after_pop = cnt_q - {1'b0, pop};

  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    cnt_d     = cnt_after_pop + {1'b0, capture};
    discard_d = discard_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (capture) begin
      if (cnt_after_pop == 2'd0) begin
        buf0_d = i_fifo_data;
      end else begin
        buf1_d = i_fifo_data;
      end
    end
    if (i_flush) begin
      cnt_d = 2'd0;
      // If the outstanding word lands in the flush cycle it is already dropped above;
      // otherwise remember to drop it when it shows up.
      discard_d = (inflight_q | discard_q) & ~i_fifo_rd_done;
    end else if (discard_q && i_fifo_rd_done) begin
      discard_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= o_fifo_rd;
      discard_q  <= discard_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [G_CNT_WIDTH-1:0] rd_count_q;

  // Not cleared by flush: counts every word that left the block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_count_q <= '0;
    end else if (pop) begin
      rd_count_q <= rd_count_q + 1'b1;
    end
  end

  assign o_rd_count = rd_count_q;
`else
  assign o_rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_rd;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data = '0;
  logic          rd_done = 1'b0;
  logic          flush;
  logic          valid;
  logic          ready;
  logic [W-1:0]  data;
  logic [CW-1:0] rd_count;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .G_WIDTH     (W),
    .G_CNT_WIDTH (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .o_fifo_rd      (fifo_rd),
    .i_fifo_empty   (fifo_empty),
    .i_fifo_data    (fifo_data),
    .i_fifo_rd_done (rd_done),
    .i_flush        (flush),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_data         (data),
    .o_rd_count     (rd_count)
  );

  // FIFO model: preloaded storage, writer bumps wr_ptr, one-cycle registered read.
  logic [W-1:0] mem [0:63];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  bit           rd_s = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(negedge clk) rd_s <= fifo_rd;

  always @(posedge clk) begin
    rd_done <= rd_s;
    if (rd_s) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef FIFO_RD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  function automatic logic [31:0] exp_cnt(input int n);
    return STATS ? 32'(n % 16) : 32'd0;
  endfunction

  initial begin
    logic [5:0] e_rd;
    logic [5:0] e_val;
    logic [7:0] e_dat [6];
    int         n_rd;

    // Preload: 0..2 test1, 3..10 test2, 11..14 flush, 15..17 reset, 18..34 stats.
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    for (int i = 0; i < 8; i++) mem[3 + i] = 8'(8'h40 + i);
    mem[11] = 8'hA1; mem[12] = 8'hA2; mem[13] = 8'hA3; mem[14] = 8'hA4;
    mem[15] = 8'h51; mem[16] = 8'h52; mem[17] = 8'h53;
    for (int i = 0; i < 17; i++) mem[18 + i] = 8'(8'h60 + i);

    rst_n = 1'b0;
    ready = 1'b0;
    flush = 1'b0;
    #1;
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_data", 32'(data), 0);
    check_eq("rst_rd", 32'(fifo_rd), 0);
    check_eq("rst_count", 32'(rd_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;

    // Three words, ready high: reads in 0,1,2, data in 2,3,4.
    e_rd  = 6'b000111;
    e_val = 6'b011100;
    e_dat = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    next_cycle();
    wr_ptr = 3;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) next_cycle();
      @(negedge clk);
      check_eq($sformatf("t1_rd%0d", c), 32'(fifo_rd), 32'(e_rd[c]));
      check_eq($sformatf("t1_val%0d", c), 32'(valid), 32'(e_val[c]));
      if (e_val[c]) check_eq($sformatf("t1_dat%0d", c), 32'(data), 32'(e_dat[c]));
    end
    check_eq("t1_count", 32'(rd_count), exp_cnt(3));

    // Eight words under back-pressure: two reads, head stable, then streaming.
    next_cycle();
    ready  = 1'b0;
    wr_ptr = 11;
    n_rd   = 0;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) next_cycle();
      @(negedge clk);
      n_rd += int'(fifo_rd);
      if (c >= 3) begin
        check_eq($sformatf("t2_hold_val%0d", c), 32'(valid), 1);
        check_eq($sformatf("t2_hold_dat%0d", c), 32'(data), 'h40);
      end
    end
    check_eq("t2_nreads", 32'(n_rd), 2);
    next_cycle();
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) next_cycle();
      @(negedge clk);
      check_eq($sformatf("t2_val%0d", i), 32'(valid), 1);
      check_eq($sformatf("t2_dat%0d", i), 32'(data), 32'('h40 + i));
    end
    next_cycle();
    @(negedge clk);
    check_eq("t2_drained", 32'(valid), 0);

    // Empty FIFO: no reads, no output.
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      check_eq($sformatf("t3_rd%0d", c), 32'(fifo_rd), 0);
      check_eq($sformatf("t3_val%0d", c), 32'(valid), 0);
    end

    // Flush with A3 in flight: A3 dropped, A4 first delivered.
    next_cycle();
    ready  = 1'b0;
    wr_ptr = 15;
    repeat (3) next_cycle();
    ready = 1'b1;
    @(negedge clk);
    check_eq("t4_rd_a3", 32'(fifo_rd), 1);
    check_eq("t4_dat_a1", 32'(data), 'hA1);
    next_cycle();
    ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check_eq("t4_rd_flush", 32'(fifo_rd), 0);
    check_eq("t4_dat_a2", 32'(data), 'hA2);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check_eq("t4_val_after_flush", 32'(valid), 0);
    check_eq("t4_rd_a4", 32'(fifo_rd), 1);
    next_cycle();
    ready = 1'b1;
    @(negedge clk);
    check_eq("t4_val_gap", 32'(valid), 0);
    next_cycle();
    @(negedge clk);
    check_eq("t4_val_a4", 32'(valid), 1);
    check_eq("t4_dat_a4", 32'(data), 'hA4);
    next_cycle();
    @(negedge clk);
    check_eq("t4_val_end", 32'(valid), 0);
    check_eq("t4_count", 32'(rd_count), exp_cnt(13));

    // Asynchronous reset while the buffer is full.
    next_cycle();
    ready  = 1'b0;
    wr_ptr = 18;
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("t5_full_val", 32'(valid), 1);
    check_eq("t5_full_dat", 32'(data), 'h51);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_val", 32'(valid), 0);
    check_eq("t5_async_dat", 32'(data), 0);
    check_eq("t5_async_cnt", 32'(rd_count), 0);
    check_eq("t5_async_rd", 32'(fifo_rd), 0);
    next_cycle();
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    check_eq("t5_rd_after", 32'(fifo_rd), 1);
    repeat (2) next_cycle();
    @(negedge clk);
    check_eq("t5_val_53", 32'(valid), 1);
    check_eq("t5_dat_53", 32'(data), 'h53);

    // Counter wrap: 17 words with a 4-bit counter.
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_count_zero", 32'(rd_count), 0);
    next_cycle();
    wr_ptr = 35;
    repeat (25) next_cycle();
    @(negedge clk);
    check_eq("t6_val_end", 32'(valid), 0);
    check_eq("t6_count_wrap", 32'(rd_count), exp_cnt(17));

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
